// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
// Contents:
//   PAR_NONE / PAR_ODD / PAR_EVEN  parity mode encodings for the PARITY parameter
//   DEFAULT_CLKS_PER_BIT           10 MHz clock at 115200 baud
//   tx_state_t                     transmitter FSM states
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 87;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO buffering words ahead of the serialiser.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset
//   push, wdata   write strobe and data; ignored while full
//   pop, rdata    read strobe and head-of-queue data (rdata valid while !empty)
//   full          registered full flag
//   empty         no words held
//   count         words held, 0..DEPTH
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q;
  logic             do_push, do_pop;

  // A full FIFO refuses writes even when a pop lands in the same cycle.
  assign do_push = push && !full_q;
  assign do_pop  = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      // Depth is a power of two, so the pointers wrap on their own.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO. Frames are LSB-first with
// optional parity and 1 or 2 stop bits; queued words go out back-to-back.
// Ports:
//   clk, reset_n      clock and asynchronous active-low reset
//   uart_tx_en        write strobe, accepted when uart_tx_ready is high
//   uart_tx_data      word to send
//   uart_tx_ready     FIFO not full (registered)
//   uart_txd          serial line, idles high
//   uart_tx_busy      a frame is on the line
//   uart_tx_count     words waiting in the FIFO (frame in flight excluded)
//   uart_tx_overflow  one-cycle pulse after a dropped write
module uart_tx_param import uart_pkg::*; #(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PAR_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          uart_tx_en,
  input  logic [DATA_BITS-1:0]          uart_tx_data,
  output logic                          uart_tx_ready,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   uart_tx_count,
  output logic                          uart_tx_overflow
);

  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);

  tx_state_t              state_q, state_d;
  logic [BaudW-1:0]       baud_q, baud_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   ovf_q;

  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic                   bit_tick, par_load;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (uart_tx_en && !fifo_full),
    .wdata   (uart_tx_data),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (uart_tx_count)
  );

  assign bit_tick = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  // Even parity is the XOR of the data bits; odd parity inverts it.
  assign par_load = (^fifo_rdata) ^ (PARITY == PAR_ODD);

  always_comb begin
    state_d  = state_q;
    baud_d   = (state_q == StIdle) ? '0 : baud_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    fifo_pop = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_rdata;
          par_d    = par_load;
          bit_d    = '0;
          baud_d   = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          baud_d  = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          baud_d  = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == BitW'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        // bit_q counts stop bits here.
        if (bit_tick) begin
          baud_d = '0;
          if (bit_q == BitW'(STOP_BITS - 1)) begin
            bit_d = '0;
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rdata;
              par_d    = par_load;
              state_d  = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Line value follows the next state so txd and busy change on the same edge.
    case (state_d)
      StStart:  txd_d = 1'b0;
      StData:   txd_d = shreg_d[0];
      StParity: txd_d = par_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      ovf_q   <= uart_tx_en && fifo_full;
    end
  end

  assign uart_txd         = txd_q;
  assign uart_tx_busy     = (state_q != StIdle);
  assign uart_tx_ready    = !fifo_full;
  assign uart_tx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: an 8N1 instance and a 7-bit odd-parity
// two-stop-bit instance, both at 4 clocks per bit with a 4-deep FIFO.
module tb_uart_tx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       en1, ready1, txd1, busy1, ovf1;
  logic [7:0] data1;
  logic [2:0] count1;
  logic       en2, ready2, txd2, busy2, ovf2;
  logic [6:0] data2;
  logic [2:0] count2;

  int checks = 0;
  int errors = 0;
  int sel = 0;

  logic       txd_s, busy_s;
  logic [2:0] count_s;
  assign txd_s   = (sel == 0) ? txd1 : txd2;
  assign busy_s  = (sel == 0) ? busy1 : busy2;
  assign count_s = (sel == 0) ? count1 : count2;

  uart_tx_param #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (8),
    .PARITY       (0),
    .STOP_BITS    (1),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .uart_tx_en       (en1),
    .uart_tx_data     (data1),
    .uart_tx_ready    (ready1),
    .uart_txd         (txd1),
    .uart_tx_busy     (busy1),
    .uart_tx_count    (count1),
    .uart_tx_overflow (ovf1)
  );

  uart_tx_param #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (7),
    .PARITY       (1),
    .STOP_BITS    (2),
    .FIFO_DEPTH   (4)
  ) dut2 (
    .clk              (clk),
    .reset_n          (reset_n),
    .uart_tx_en       (en2),
    .uart_tx_data     (data2),
    .uart_tx_ready    (ready2),
    .uart_txd         (txd2),
    .uart_tx_busy     (busy2),
    .uart_tx_count    (count2),
    .uart_tx_overflow (ovf2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // frame[k] is the k-th bit on the line, starting with the start bit.
  typedef struct {
    int          s;
    logic [8:0]  data;
    int          nbits;
    logic [11:0] frame;
  } vec_t;

  task automatic run_frame(input int s, input logic [8:0] d, input int nbits,
                           input logic [11:0] frame);
    sel = s;
    @(negedge clk);
    if (s == 0) begin en1 = 1'b1; data1 = d[7:0]; end
    else        begin en2 = 1'b1; data2 = d[6:0]; end
    @(negedge clk);
    check($sformatf("frame %0h count after push", d), 32'(count_s), 32'd1);
    check($sformatf("frame %0h busy before pop", d), 32'(busy_s), 32'd0);
    en1 = 1'b0;
    en2 = 1'b0;
    for (int i = 0; i < nbits * 4; i++) begin
      @(negedge clk);
      if (i == 0) check($sformatf("frame %0h count after pop", d), 32'(count_s), 32'd0);
      check($sformatf("frame %0h txd cycle %0d", d, i), 32'(txd_s), 32'(frame[i / 4]));
      check($sformatf("frame %0h busy cycle %0d", d, i), 32'(busy_s), 32'd1);
    end
    @(negedge clk);
    check($sformatf("frame %0h busy after", d), 32'(busy_s), 32'd0);
    check($sformatf("frame %0h txd after", d), 32'(txd_s), 32'd1);
  endtask

  vec_t        vecs [9];
  logic [9:0]  b2b_frames [3];
  logic [9:0]  ovf_frames [5];
  logic [2:0]  ovf_exp_cnt [6];
  logic        ovf_exp_rdy [6];

  initial begin
    vecs[0] = '{0, 9'h0A5, 10, 12'b001101001010};
    vecs[1] = '{0, 9'h000, 10, 12'b001000000000};
    vecs[2] = '{0, 9'h0FF, 10, 12'b001111111110};
    vecs[3] = '{0, 9'h05A, 10, 12'b001010110100};
    vecs[4] = '{0, 9'h001, 10, 12'b001000000010};
    vecs[5] = '{0, 9'h080, 10, 12'b001100000000};
    // 7 data bits, odd parity, 2 stop bits
    vecs[6] = '{1, 9'h003, 11, 12'b011100000110};
    vecs[7] = '{1, 9'h007, 11, 12'b011000001110};
    vecs[8] = '{1, 9'h040, 11, 12'b011010000000};

    b2b_frames[0] = 10'b1000100010;  // 0x11
    b2b_frames[1] = 10'b1001000100;  // 0x22
    b2b_frames[2] = 10'b1001100110;  // 0x33

    ovf_frames[0] = 10'b1000000010;  // 0x01
    ovf_frames[1] = 10'b1000000100;  // 0x02
    ovf_frames[2] = 10'b1000000110;  // 0x03
    ovf_frames[3] = 10'b1000001000;  // 0x04
    ovf_frames[4] = 10'b1000001010;  // 0x05
    ovf_exp_cnt = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    ovf_exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset held with writes attempted: everything stays idle.
    reset_n = 1'b0;
    en1 = 1'b1; data1 = 8'hC3;
    en2 = 1'b1; data2 = 7'h15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset txd", 32'(txd1), 32'd1);
      check("reset busy", 32'(busy1), 32'd0);
      check("reset ready", 32'(ready1), 32'd1);
      check("reset count", 32'(count1), 32'd0);
      check("reset overflow", 32'(ovf1), 32'd0);
      check("reset txd2", 32'(txd2), 32'd1);
    end
    en1 = 1'b0;
    en2 = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post-reset txd", 32'(txd1), 32'd1);
      check("post-reset busy", 32'(busy1), 32'd0);
      check("post-reset count", 32'(count1), 32'd0);
    end

    // Single frames from the table.
    for (int v = 0; v < 9; v++) begin
      run_frame(vecs[v].s, vecs[v].data, vecs[v].nbits, vecs[v].frame);
    end

    // Back-to-back: three pushes on consecutive cycles, no idle gap on the line.
    sel = 0;
    @(negedge clk);
    en1 = 1'b1; data1 = 8'h11;
    @(negedge clk);
    check("b2b count after first push", 32'(count1), 32'd1);
    data1 = 8'h22;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      check($sformatf("b2b txd cycle %0d", i), 32'(txd1),
            32'(b2b_frames[i / 40][(i % 40) / 4]));
      check($sformatf("b2b busy cycle %0d", i), 32'(busy1), 32'd1);
      if (i == 0) begin
        check("b2b count push+pop", 32'(count1), 32'd1);
        data1 = 8'h33;
      end
      if (i == 1) begin
        check("b2b count two queued", 32'(count1), 32'd2);
        en1 = 1'b0;
      end
      if (i == 40) check("b2b count frame2", 32'(count1), 32'd1);
      if (i == 80) check("b2b count frame3", 32'(count1), 32'd0);
    end
    @(negedge clk);
    check("b2b busy after", 32'(busy1), 32'd0);
    check("b2b txd after", 32'(txd1), 32'd1);

    // Overflow: six pushes into a 4-deep FIFO; word 6 is dropped.
    @(negedge clk);
    en1 = 1'b1; data1 = 8'h01;
    for (int c = 0; c <= 201; c++) begin
      @(negedge clk);
      if (c <= 5) begin
        check($sformatf("ovf count c%0d", c), 32'(count1), 32'(ovf_exp_cnt[c]));
        check($sformatf("ovf ready c%0d", c), 32'(ready1), 32'(ovf_exp_rdy[c]));
        check($sformatf("ovf pulse c%0d", c), 32'(ovf1), (c == 5) ? 32'd1 : 32'd0);
      end
      if (c == 6) check("ovf pulse clears", 32'(ovf1), 32'd0);
      if (c == 41) begin
        check("ovf ready after pop", 32'(ready1), 32'd1);
        check("ovf count after pop", 32'(count1), 32'd3);
      end
      if (c >= 1 && c <= 200) begin
        check($sformatf("ovf txd c%0d", c), 32'(txd1),
              32'(ovf_frames[(c - 1) / 40][((c - 1) % 40) / 4]));
        check($sformatf("ovf busy c%0d", c), 32'(busy1), 32'd1);
      end
      if (c == 201) begin
        check("ovf busy after", 32'(busy1), 32'd0);
        check("ovf count after", 32'(count1), 32'd0);
        check("ovf txd after", 32'(txd1), 32'd1);
      end
      if (c < 5) data1 = 8'(c + 2);
      else en1 = 1'b0;
    end

    // Reset during data bit 3 of 0xA5 (bit 3 is 0, so the line is low).
    @(negedge clk);
    en1 = 1'b1; data1 = 8'hA5;
    @(negedge clk);
    en1 = 1'b0;
    for (int i = 0; i <= 17; i++) @(negedge clk);
    check("midreset line low before", 32'(txd1), 32'd0);
    check("midreset busy before", 32'(busy1), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midreset txd async", 32'(txd1), 32'd1);
    check("midreset busy async", 32'(busy1), 32'd0);
    check("midreset count async", 32'(count1), 32'd0);
    @(negedge clk);
    check("midreset txd held", 32'(txd1), 32'd1);
    reset_n = 1'b1;
    @(negedge clk);
    check("midreset idle after release", 32'(busy1), 32'd0);
    run_frame(0, 9'h05A, 10, 12'b001010110100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
